// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - issue/writeback handshake bundle for the multi-cycle ALU
interface alu_mc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             negative;
    logic             err;

    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, negative, err
    );

    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, negative, err
    );
endinterface

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle logic/arith/shift ops plus shift-add MUL
module alu_mc #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_SLTU = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               carry_q;
    logic               overflow_q;
    logic               negative_q;
    logic               err_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW-1:0]     cnt_q;

    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_carry_d;
    logic               alu_ovf_d;
    logic               alu_ill_d;
    logic               is_mul;
    logic [WIDTH:0]     sum_w;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] acc_d;

    assign is_mul = MUL_EN && (bus.op == OP_MUL);
    assign acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle ops evaluate the live bus; the result is only kept on the accept edge.
    always_comb begin
        shamt       = bus.B[SHW-1:0];
        sum_w       = {1'b0, bus.A} + {1'b0, bus.B};
        alu_res_d   = '0;
        alu_carry_d = 1'b0;
        alu_ovf_d   = 1'b0;
        alu_ill_d   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res_d   = sum_w[WIDTH-1:0];
                alu_carry_d = sum_w[WIDTH];
                alu_ovf_d   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                              (alu_res_d[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_d   = bus.A - bus.B;
                alu_carry_d = (bus.A < bus.B);
                alu_ovf_d   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                              (alu_res_d[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  alu_res_d = bus.A & bus.B;
            OP_OR:   alu_res_d = bus.A | bus.B;
            OP_XOR:  alu_res_d = bus.A ^ bus.B;
            OP_NOR:  alu_res_d = ~(bus.A | bus.B);
            OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLL:  alu_res_d = bus.A << shamt;
            OP_SRL:  alu_res_d = bus.A >> shamt;
            OP_SRA:  alu_res_d = $unsigned($signed(bus.A) >>> shamt);
            default: alu_ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            negative_q <= 1'b0;
            err_q      <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (is_mul) begin
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, bus.A};
                            mplier_q <= bus.B;
                            cnt_q    <= SHW'(WIDTH - 1);
                            state_q  <= S_MUL;
                        end else begin
                            // Illegal ops leave alu_res_d at zero, so zero_q comes out set.
                            result_q   <= alu_res_d;
                            zero_q     <= (alu_res_d == '0);
                            carry_q    <= alu_carry_d;
                            overflow_q <= alu_ovf_d;
                            negative_q <= alu_res_d[WIDTH-1];
                            err_q      <= alu_ill_d;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - SHW'(1);
                    if (cnt_q == '0) begin
                        result_q   <= acc_d[WIDTH-1:0];
                        zero_q     <= (acc_d[WIDTH-1:0] == '0);
                        carry_q    <= |acc_d[2*WIDTH-1:WIDTH];
                        overflow_q <= 1'b0;
                        negative_q <= acc_d[WIDTH-1];
                        err_q      <= 1'b0;
                        state_q    <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.negative  = negative_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc (8-bit with MUL, 16-bit without MUL)
module tb_alu_mc;
    typedef struct {
        logic [15:0] res;
        logic [4:0]  fl;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        int          d;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [4:0]  fl;
    } vec_t;

    logic clk;
    logic rst_n;
    logic hold;
    int   cyc;
    int   vecs;
    int   fails;

    logic        iv[2];
    logic [15:0] ia[2];
    logic [15:0] ib[2];
    logic [3:0]  iop[2];
    logic        ordy[2];
    logic        ir[2];
    logic        ovld[2];
    logic [15:0] res[2];
    logic [4:0]  fl[2];

    exp_t sb[2][$];
    bit   seen[2];
    exp_t mon_e;

    alu_mc_if #(.WIDTH(8))  bus8 ();
    alu_mc_if #(.WIDTH(16)) bus16 ();

    alu_mc #(.WIDTH(8),  .MUL_EN(1'b1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    alu_mc #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    assign bus8.in_valid  = iv[0];
    assign bus8.A         = ia[0][7:0];
    assign bus8.B         = ib[0][7:0];
    assign bus8.op        = iop[0];
    assign bus8.out_ready = ordy[0];
    assign ir[0]   = bus8.in_ready;
    assign ovld[0] = bus8.out_valid;
    assign res[0]  = {8'h00, bus8.result};
    assign fl[0]   = {bus8.zero, bus8.carry, bus8.overflow, bus8.negative, bus8.err};

    assign bus16.in_valid  = iv[1];
    assign bus16.A         = ia[1];
    assign bus16.B         = ib[1];
    assign bus16.op        = iop[1];
    assign bus16.out_ready = ordy[1];
    assign ir[1]   = bus16.in_ready;
    assign ovld[1] = bus16.out_valid;
    assign res[1]  = bus16.result;
    assign fl[1]   = {bus16.zero, bus16.carry, bus16.overflow, bus16.negative, bus16.err};

    // Directed vectors: d, op, A, B, result, {zero,carry,overflow,negative,err}
    vec_t tbl[16] = '{
        '{0, 4'h0, 16'h0078, 16'h0008, 16'h0080, 5'b00110},
        '{0, 4'h3, 16'h0004, 16'h0010, 16'h00F4, 5'b01010},
        '{0, 4'h3, 16'h0010, 16'h0004, 16'h000C, 5'b00000},
        '{0, 4'h5, 16'h0072, 16'h008F, 16'h0000, 5'b10000},
        '{0, 4'hB, 16'h0072, 16'h008F, 16'h0001, 5'b00000},
        '{0, 4'h9, 16'h0090, 16'h0003, 16'h00F2, 5'b00010},
        '{0, 4'h8, 16'h0090, 16'h0003, 16'h0012, 5'b00000},
        '{0, 4'hA, 16'h0013, 16'h0011, 16'h0043, 5'b01000},
        '{0, 4'hC, 16'h0012, 16'h0034, 16'h0000, 5'b10001},
        '{0, 4'h7, 16'h00A5, 16'h0008, 16'h00A5, 5'b00010},
        '{0, 4'h9, 16'h0090, 16'h0000, 16'h0090, 5'b00010},
        '{0, 4'h7, 16'h0001, 16'h000F, 16'h0080, 5'b00010},
        '{1, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00110},
        '{1, 4'hA, 16'h0003, 16'h0004, 16'h0000, 5'b10001},
        '{1, 4'h3, 16'h0000, 16'h0001, 16'hFFFF, 5'b01010},
        '{1, 4'h9, 16'h8000, 16'h0014, 16'hF800, 5'b00010}
    };

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model from the opcode definitions using wide signed integer arithmetic.
    function automatic exp_t model(int d, logic [3:0] op, logic [15:0] a, logic [15:0] b);
        exp_t   x;
        int     w     = (d == 0) ? 8 : 16;
        bit     mulen = (d == 0);
        longint mask  = (longint'(1) << w) - 1;
        longint hi    = (longint'(1) << (w - 1)) - 1;
        longint lo    = -(longint'(1) << (w - 1));
        longint ua    = longint'(a) & mask;
        longint ub    = longint'(b) & mask;
        longint sa    = (ua > hi) ? ua - (mask + 1) : ua;
        longint sb_   = (ub > hi) ? ub - (mask + 1) : ub;
        int     sh    = int'(ub % w);
        longint r     = 0;
        bit     c     = 0;
        bit     v     = 0;
        bit     e     = 0;
        case (op)
            4'h0: begin r = ua + ub; c = (r > mask); v = (sa + sb_ > hi) || (sa + sb_ < lo); end
            4'h1: r = ua & ub;
            4'h2: r = ua | ub;
            4'h3: begin r = ua - ub; c = (ua < ub); v = (sa - sb_ > hi) || (sa - sb_ < lo); end
            4'h4: r = ua ^ ub;
            4'h5: r = (sa < sb_) ? 1 : 0;
            4'h6: r = ~(ua | ub);
            4'h7: r = ua << sh;
            4'h8: r = ua >> sh;
            4'h9: r = sa >>> sh;
            4'hA: if (mulen) begin r = ua * ub; c = ((r >> w) != 0); end else e = 1;
            4'hB: r = (ua < ub) ? 1 : 0;
            default: e = 1;
        endcase
        r = e ? 0 : (r & mask);
        x.res = 16'(r);
        x.fl  = {(r == 0), c, v, bit'((r >> (w - 1)) & 1), e};
        x.lat = 0;
        x.acc = 0;
        return x;
    endfunction

    task automatic issue(int d, logic [3:0] op, logic [15:0] a, logic [15:0] b,
                         bit use_exp, exp_t ex);
        exp_t e;
        int   n = 0;
        while (!ir[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ir[d]) begin
            vecs++;
            fails++;
            $display("FAIL issue_timeout dut%0d: in_ready stayed 0, required 1", d);
            return;
        end
        e     = use_exp ? ex : model(d, op, a, b);
        e.lat = (d == 0 && op == 4'hA) ? 8 : 0;
        e.acc = cyc + 1;
        sb[d].push_back(e);
        iv[d] = 1'b1; iop[d] = op; ia[d] = a; ib[d] = b;
        @(negedge clk);
        iv[d] = 1'b0; ia[d] = 16'($urandom); ib[d] = 16'($urandom); iop[d] = 4'($urandom);
    endtask

    task automatic check_idle(int d, string name);
        vecs++;
        if (ir[d] !== 1'b1 || ovld[d] !== 1'b0 || res[d] !== 16'h0 || fl[d] !== 5'b0) begin
            fails++;
            $display("FAIL %s dut%0d: in_ready=%b out_valid=%b result=%h flags=%b, required 1 0 0000 00000",
                     name, d, ir[d], ovld[d], res[d], fl[d]);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb[0].size() != 0 || sb[1].size() != 0) begin
            vecs++;
            fails++;
            $display("FAIL drain_timeout: pending %0d/%0d results, required 0/0", sb[0].size(), sb[1].size());
        end
        @(negedge clk);
    endtask

    initial begin
        forever begin
            ordy[0] = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            ordy[1] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
    end

    // Monitor: compares every presented result (held cycles included) against the queue head.
    initial begin
        seen[0] = 0;
        seen[1] = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                seen[0] = 0;
                seen[1] = 0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    vecs++;
                    if (ir[d] && ovld[d]) begin
                        fails++;
                        $display("FAIL ready_valid_overlap dut%0d: both high, required exclusive", d);
                    end
                    if (ovld[d]) begin
                        vecs++;
                        if (sb[d].size() == 0) begin
                            fails++;
                            $display("FAIL unexpected_out_valid dut%0d: result=%h with nothing issued", d, res[d]);
                        end else begin
                            mon_e = sb[d][0];
                            if (res[d] !== mon_e.res || fl[d] !== mon_e.fl) begin
                                fails++;
                                $display("FAIL result dut%0d: got %h flags %b, required %h flags %b",
                                         d, res[d], fl[d], mon_e.res, mon_e.fl);
                            end
                            if (!seen[d]) begin
                                vecs++;
                                seen[d] = 1;
                                if (cyc - mon_e.acc != mon_e.lat) begin
                                    fails++;
                                    $display("FAIL latency dut%0d: %0d edges after accept, required %0d",
                                             d, cyc - mon_e.acc, mon_e.lat);
                                end
                            end
                            if (ordy[d]) begin
                                void'(sb[d].pop_front());
                                seen[d] = 0;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        exp_t ex;
        cyc   = 0;
        vecs  = 0;
        fails = 0;
        hold  = 1'b0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ia[d] = '0; ib[d] = '0; iop[d] = '0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "reset_state");
        check_idle(1, "reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            ex.res = tbl[i].res;
            ex.fl  = tbl[i].fl;
            issue(tbl[i].d, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, ex);
        end
        wait_drain();

        // Held result with competing in_valid traffic that must be ignored.
        hold   = 1'b1;
        ex.res = tbl[0].res;
        ex.fl  = tbl[0].fl;
        issue(0, tbl[0].op, tbl[0].a, tbl[0].b, 1'b1, ex);
        iv[0] = 1'b1; iop[0] = 4'h3; ia[0] = 16'h00FF; ib[0] = 16'h0001;
        repeat (5) @(negedge clk);
        iv[0] = 1'b0;
        hold  = 1'b0;
        wait_drain();

        // Reset in the middle of a multiply discards it.
        issue(0, 4'hA, 16'h00FF, 16'h00FF, 1'b0, ex);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb[0].delete();
        #1;
        check_idle(0, "mid_mul_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_idle(0, "post_reset_idle");

        for (int i = 0; i < 160; i++) begin
            int d = int'($urandom_range(0, 1));
            issue(d, 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'b0, ex);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
